// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared widths and state encoding for the decode stage pipe controller
package decode_pkg;

    localparam int FID_W         = 8;
    localparam int PAYLOAD_W_DEF = 160;

    // Encoding doubles as the occupancy count driven on o_count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pctl_state_t;

endpackage

// File: rtl/decode_pctl_buf.sv
// rtl/decode_pctl_buf.sv - two-entry payload/FID storage, written and read by external pointers
module decode_pctl_buf
    import decode_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic                 wr_ptr,
    input  logic [PAYLOAD_W-1:0] wr_payload,
    input  logic [FID_W-1:0]     wr_fid,
    input  logic                 rd_ptr,
    output logic [PAYLOAD_W-1:0] rd_payload,
    output logic [FID_W-1:0]     rd_fid
);

    // Storage is intentionally not reset; o_valid qualifies the read side.
    logic [PAYLOAD_W-1:0] payload_q [2];
    logic [FID_W-1:0]     fid_q     [2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            payload_q[wr_ptr] <= wr_payload;
            fid_q[wr_ptr]     <= wr_fid;
        end
    end

    assign rd_payload = payload_q[rd_ptr];
    assign rd_fid     = fid_q[rd_ptr];

endmodule

// File: rtl/decode_pipectrl.sv
// rtl/decode_pipectrl.sv - decode register stage handshake, FID tagging and flush control
module decode_pipectrl
    import decode_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 snoop_hit,
    input  logic                 bco_valid,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [FID_W-1:0]     o_fid,
    output logic [1:0]           o_count
);

    localparam logic [FID_W-1:0] FID_ONE = 1;

    pctl_state_t      state_q, state_d;
    logic             wr_ptr_q, rd_ptr_q;
    logic [FID_W-1:0] fid_q;
    logic             flush, push, pop;

    assign flush   = snoop_hit | bco_valid;
    assign i_ready = resetn & (state_q != ST_FULL);
    assign o_valid = resetn & (state_q != ST_EMPTY) & ~flush;
    assign push    = i_valid & i_ready & ~flush;
    assign pop     = o_valid & o_ready;
    assign o_count = resetn ? state_q : ST_EMPTY;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (push) state_d = ST_ONE;
                ST_ONE: begin
                    if (push && !pop)      state_d = ST_FULL;
                    else if (!push && pop) state_d = ST_EMPTY;
                end
                ST_FULL:  if (pop) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // The FID counter survives flushes so retried bundles never reuse a live tag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fid_q    <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
            end
            if (push) fid_q <= fid_q + FID_ONE;
        end
    end

    decode_pctl_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_buf (
        .clk        (clk),
        .wr_en      (push),
        .wr_ptr     (wr_ptr_q),
        .wr_payload (i_payload),
        .wr_fid     (fid_q),
        .rd_ptr     (rd_ptr_q),
        .rd_payload (o_payload),
        .rd_fid     (o_fid)
    );

endmodule

// File: tb/tb_decode_pipectrl.sv
// tb/tb_decode_pipectrl.sv - scoreboard bench for decode_pipectrl
module tb_decode_pipectrl;
    import decode_pkg::*;

    localparam int PW = 160;

    logic          clk = 1'b1;
    logic          resetn = 1'b0;
    logic          snoop_hit = 1'b0;
    logic          bco_valid = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready = 1'b0;
    logic [PW-1:0] i_payload = '0;
    logic          i_ready, o_valid;
    logic [PW-1:0] o_payload;
    logic [FID_W-1:0] o_fid;
    logic [1:0]    o_count;

    decode_pipectrl #(.PAYLOAD_W(PW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .snoop_hit (snoop_hit),
        .bco_valid (bco_valid),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_payload (i_payload),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_payload (o_payload),
        .o_fid     (o_fid),
        .o_count   (o_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [7:0]    f;
    } ent_t;

    ent_t       sb[$];
    logic [7:0] seen[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         mcount = 0;
    logic [7:0] mfid = 8'd0;
    bit         chk_en = 1'b0;
    bit         exp_ov, exp_ir;
    int         exp_cnt;
    ent_t       e;

    function automatic void check_int(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void check_wide(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [PW-1:0] pl(int k);
        logic [31:0] w;
        w = 32'(k) ^ 32'hC0DE0000;
        return {5{w}};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check_int("o_valid", int'(o_valid), int'(exp_ov));
            check_int("i_ready", int'(i_ready), int'(exp_ir));
            check_int("o_count", int'(o_count), exp_cnt);
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got fid %0d expected no pop at %0t", o_fid, $time);
                end else begin
                    e = sb.pop_front();
                    check_wide("o_payload", o_payload, e.p);
                    check_int("o_fid", int'(o_fid), int'(e.f));
                    seen.push_back(o_fid);
                end
            end
        end
    end

    task automatic step(bit rn, bit iv, logic [PW-1:0] p, bit ordy, bit sh, bit bc);
        bit fl, pu, po;
        resetn    = rn;
        i_valid   = iv;
        i_payload = p;
        o_ready   = ordy;
        snoop_hit = sh;
        bco_valid = bc;
        fl = sh | bc;
        if (!rn) begin
            exp_ov = 1'b0; exp_ir = 1'b0; exp_cnt = 0; pu = 1'b0; po = 1'b0;
        end else begin
            exp_ir  = (mcount != 2);
            exp_ov  = (mcount != 0) && !fl;
            exp_cnt = mcount;
            pu = iv && exp_ir && !fl;
            po = exp_ov && ordy;
        end
        if (pu) sb.push_back({p, mfid});
        chk_en = 1'b1;
        @(posedge clk);
        if (!rn) begin
            mcount = 0; mfid = 8'd0; sb.delete();
        end else if (fl) begin
            mcount = 0; sb.delete();
        end else begin
            mcount = mcount + int'(pu) - int'(po);
            if (pu) mfid = mfid + 8'd1;
        end
        #1;
    endtask

    initial begin
        int wraps;
        step(0, 0, '0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 0);

        // streaming with o_ready high: fids 0,1,2
        step(1, 1, pl(1), 1, 0, 0);
        step(1, 1, pl(2), 1, 0, 0);
        step(1, 1, pl(3), 1, 0, 0);
        step(1, 0, '0, 1, 0, 0);
        check_int("t1_npop", seen.size(), 3);
        check_int("t1_fid0", int'(seen[0]), 0);
        check_int("t1_fid1", int'(seen[1]), 1);
        check_int("t1_fid2", int'(seen[2]), 2);

        // backpressure to FULL, then drain with C accepted late
        step(1, 1, pl(4), 0, 0, 0);
        step(1, 1, pl(5), 0, 0, 0);
        step(1, 1, pl(6), 0, 0, 0);
        step(1, 1, pl(6), 1, 0, 0);
        step(1, 1, pl(6), 1, 0, 0);
        step(1, 0, '0, 1, 0, 0);
        check_int("t2_npop", seen.size(), 6);
        check_int("t2_fid_a", int'(seen[3]), 3);
        check_int("t2_fid_b", int'(seen[4]), 4);
        check_int("t2_fid_c", int'(seen[5]), 5);

        // bco flush from FULL with an offered bundle
        step(1, 1, pl(7), 0, 0, 0);
        step(1, 1, pl(8), 0, 0, 0);
        step(1, 1, pl(9), 0, 0, 1);
        step(1, 1, pl(10), 0, 0, 0);
        step(1, 0, '0, 1, 0, 0);
        check_int("t3_npop", seen.size(), 7);
        check_int("t3_fid", int'(seen[6]), 8);

        // snoop and bco together while o_ready in ONE
        step(1, 1, pl(11), 0, 0, 0);
        step(1, 0, '0, 1, 1, 1);
        step(1, 0, '0, 1, 0, 0);
        check_int("t4_npop", seen.size(), 7);

        // 300 back-to-back: fids 10..309 mod 256
        for (int i = 0; i < 300; i++) step(1, 1, pl(100 + i), 1, 0, 0);
        step(1, 0, '0, 1, 0, 0);
        check_int("t5_npop", seen.size(), 307);
        check_int("t5_first", int'(seen[7]), 10);
        check_int("t5_last", int'(seen[306]), 53);
        wraps = 0;
        for (int k = 8; k < seen.size(); k++) begin
            check_int("t5_seq", int'(seen[k]), int'(8'(seen[k-1] + 8'd1)));
            if (seen[k] == 8'd0) wraps++;
        end
        check_int("t5_wraps", wraps, 1);

        // advance counter to 77 with FULL, then reset
        for (int i = 0; i < 21; i++) step(1, 1, pl(500 + i), 1, 0, 0);
        step(1, 0, '0, 1, 0, 0);
        check_int("t6_pre", int'(seen[seen.size()-1]), 74);
        step(1, 1, pl(600), 0, 0, 0);
        step(1, 1, pl(601), 0, 0, 0);
        step(0, 1, pl(602), 1, 0, 0);
        step(1, 0, '0, 0, 0, 0);
        step(1, 1, pl(603), 0, 0, 0);
        step(1, 0, '0, 1, 0, 0);
        check_int("t6_fid", int'(seen[seen.size()-1]), 0);
        check_int("t6_npop", seen.size(), 329);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
